// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: condition codes, flag bit positions,
// reset PC and the next-PC sequencer state encoding.
package cpu_pkg;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GE     = 3'b100;
    localparam logic [2:0] CC_LE     = 3'b101;
    localparam logic [2:0] CC_V      = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam logic [15:0] PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        SEQ_RUN  = 2'd0,
        SEQ_PEND = 2'd1,
        SEQ_HALT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_reg16.sv
// 16-bit program-counter register: synchronous active-high reset to PC_RESET,
// load when i_wen is high, otherwise hold. Reset takes priority over the enable.
module pc_reg16
    import cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wen,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= PC_RESET;
        end else if (i_wen) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, B/BR redirect, stall hold and sticky halt.
// A taken branch that resolves under stall is parked in PEND and replayed on release.
module pc_sequencer
    import cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_br_valid,
    input  logic        i_br_is_reg,
    input  logic [2:0]  i_br_cond,
    input  logic [2:0]  i_flags,
    input  logic [8:0]  i_br_imm,
    input  logic [15:0] i_br_reg,
    input  logic [15:0] i_br_pc_plus2,
    input  logic        i_halt_req,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_plus2,
    output logic        o_flush,
    output logic        o_halted
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [15:0] r_pend_tgt;

    logic        w_z;
    logic        w_v;
    logic        w_n;
    logic        w_cond_ok;
    logic        w_taken;
    logic [15:0] w_b_tgt;
    logic [15:0] w_br_tgt;
    logic [15:0] w_tgt;

    logic [15:0] w_pc;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_pc_next;
    logic        w_hold;
    logic        w_flush;
    logic        w_pend_load;

    assign w_z = i_flags[FLAG_Z];
    assign w_v = i_flags[FLAG_V];
    assign w_n = i_flags[FLAG_N];

    always_comb begin
        w_cond_ok = 1'b0;
        case (i_br_cond)
            CC_NE:     w_cond_ok = !w_z;
            CC_EQ:     w_cond_ok = w_z;
            CC_GT:     w_cond_ok = !w_z && !w_n;
            CC_LT:     w_cond_ok = w_n;
            CC_GE:     w_cond_ok = w_z || (!w_z && !w_n);
            CC_LE:     w_cond_ok = w_n || w_z;
            CC_V:      w_cond_ok = w_v;
            CC_UNCOND: w_cond_ok = 1'b1;
            default:   w_cond_ok = 1'b0;
        endcase
    end

    assign w_taken = i_br_valid && w_cond_ok;

    // Word offset scaled to bytes; the add wraps modulo 2^16.
    assign w_b_tgt  = i_br_pc_plus2 + {{6{i_br_imm[8]}}, i_br_imm, 1'b0};
    assign w_br_tgt = i_br_reg & 16'hFFFE;
    assign w_tgt    = i_br_is_reg ? w_br_tgt : w_b_tgt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEQ_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_tgt <= PC_RESET;
        end else if (w_pend_load) begin
            r_pend_tgt <= w_tgt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_RUN: begin
                if (w_taken && i_stall) begin
                    w_state_nxt = SEQ_PEND;
                end else if (!w_taken && i_halt_req && !i_stall) begin
                    w_state_nxt = SEQ_HALT;
                end
            end
            SEQ_PEND: begin
                if (!i_stall) begin
                    w_state_nxt = SEQ_RUN;
                end
            end
            SEQ_HALT: w_state_nxt = SEQ_HALT;
            default:  w_state_nxt = SEQ_RUN;
        endcase
    end

    // A taken branch outranks halt_req: the younger HLT is flushed with IF/ID.
    always_comb begin
        w_hold      = 1'b1;
        w_pc_next   = w_pc_plus2;
        w_flush     = 1'b0;
        w_pend_load = 1'b0;
        case (r_state)
            SEQ_RUN: begin
                if (w_taken && !i_stall) begin
                    w_hold    = 1'b0;
                    w_pc_next = w_tgt;
                    w_flush   = 1'b1;
                end else if (w_taken) begin
                    w_pend_load = 1'b1;
                end else if (i_halt_req && !i_stall) begin
                    w_hold = 1'b1;
                end else if (!i_stall) begin
                    w_hold = 1'b0;
                end
            end
            SEQ_PEND: begin
                if (!i_stall) begin
                    w_hold    = 1'b0;
                    w_pc_next = r_pend_tgt;
                    w_flush   = 1'b1;
                end
            end
            SEQ_HALT: w_hold = 1'b1;
            default:  w_hold = 1'b1;
        endcase
    end

    pc_reg16 u_pc_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_wen (~w_hold),
        .i_d   (w_pc_next),
        .o_q   (w_pc)
    );

    assign w_pc_plus2 = w_pc + 16'd2;

    assign o_pc       = w_pc;
    assign o_pc_plus2 = w_pc_plus2;
    assign o_flush    = w_flush && !i_rst;
    assign o_halted   = (r_state == SEQ_HALT);

`ifndef SYNTHESIS
    a_halt_sticky: assert property (@(posedge i_clk) (o_halted && !i_rst) |=> o_halted);
    a_no_flush_halted: assert property (@(posedge i_clk) o_halted |-> !o_flush);
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 16-bit single-issue core. It owns the program counter and selects each cycle between sequential fetch (PC+2), PC-relative branch (B), register-indirect branch (BR), hold (pipeline stall) and halt. A small FSM holds a branch that resolves during a stall and replays it when the stall drops. Its outputs feed instruction-memory address, IF/ID flush and the top-level halt signal.

## Interface
- No parameters. Widths are fixed: 16-bit PC, 9-bit branch offset, 3-bit condition code, 3-bit flags.
- clk  in  1  single clock; everything samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold the PC this cycle.
- br_valid  in  1  decode stage has a B or BR instruction this cycle.
- br_is_reg  in  1  1 = BR (target from register), 0 = B (PC-relative).
- br_cond  in  3  condition code ccc.
- flags  in  3  {Z, V, N} from the flag register.
- br_imm  in  9  signed word offset for B.
- br_reg  in  16  register target for BR.
- br_pc_plus2  in  16  PC+2 of the branch instruction, taken from IF/ID.
- halt_req  in  1  decode stage has a HLT instruction.
- pc  out  16  current fetch address, registered.
- pc_plus2  out  16  pc + 2, combinational.
- flush  out  1  squash the IF/ID contents this cycle.
- halted  out  1  core halted, registered, sticky until rst.

## Operation
- Condition evaluation for taken:
  - 000: Z == 0
  - 001: Z == 1
  - 010: Z == 0 and N == 0
  - 011: N == 1
  - 100: Z == 1, or (Z == 0 and N == 0)
  - 101: N == 1 or Z == 1
  - 110: V == 1
  - 111: always
- Target:
  - B: br_pc_plus2 + (sign_extend(br_imm) << 1), modulo 2^16.
  - BR: br_reg, with bit 0 forced to 0.
- States:
  - RUN: normal fetch.
  - PEND: a taken branch is held while stall is asserted.
  - HALT: terminal until rst.
- RUN transitions and actions, first match wins:
  1. Taken branch and stall low: pc <= target; flush = 1; stay in RUN.
  2. Taken branch and stall high: latch target into pend_tgt; go to PEND; pc holds; flush = 0.
  3. halt_req and stall low: pc holds; go to HALT.
  4. stall high: pc holds.
  5. Otherwise: pc <= pc + 2.
- Branch vs halt: a taken branch outranks halt_req in the same cycle. The HLT is younger, so it is flushed and ignored.
- PEND:
  - stall high: hold; br_valid and halt_req are ignored, because decode is frozen.
  - stall low: pc <= pend_tgt; flush = 1; go to RUN.
- HALT:
  - pc frozen; halted = 1; flush = 0; all inputs except rst are ignored.
- Not-taken branch: same as no branch (pc + 2, or hold if stall is high).
- Wrap-around: pc 0xFFFE + 2 = 0x0000 with no error indication; target arithmetic also wraps.
- Reset outputs: pc = 0x0000, state = RUN, pend_tgt = 0x0000, halted = 0, flush = 0.
- rst asserted in any state, including mid-PEND or HALT, wins. A pending target is discarded.

## Timing
- pc updates on the clock edge after the decision. Next-pc latency is 1 cycle.
- flush is combinational and asserted in the same cycle as the redirect decision; IF/ID sees it at the same edge that loads the new pc.
- Taken branch penalty is 1 bubble, or 1 bubble after stall release when the branch was pended.
- halted rises 1 cycle after a halt_req is accepted.
- pc_plus2 is valid whenever pc is valid.
- No combinational path exists from stall to pc; only flush and next-pc depend combinationally on the inputs.

## Structure
- Shared package `cpu_pkg`:
  - ccc encodings (CC_NE … CC_UNCOND).
  - Flag bit indices (FLAG_Z = 2, FLAG_V = 1, FLAG_N = 0).
  - PC_RESET = 16'h0000.
  - Sequencer state enum {RUN, PEND, HALT}.
- One natural sub-module: `pc_reg16`, a 16-bit register with write enable and synchronous reset built from the team's dff cell. The sequencer drives wen = ~hold.
- Condition evaluation and target adders stay inline.

## Test plan
- Reset then run freely for 4 cycles with no stall → pc = 0x0000, 0x0002, 0x0004, 0x0006; halted = 0.
- B with ccc = 111, br_pc_plus2 = 0x0010, br_imm = 9'h1FC (−4), stall low → flush = 1; next pc = 0x0008.
- BR with ccc = 001, Z = 0, br_reg = 0x1235 → not taken, pc + 2. Repeat with Z = 1 → next pc = 0x1234, flush = 1.
- Taken B (target 0x0040) while stall is high for 3 cycles → pc holds, flush = 0 throughout. In the cycle stall drops, flush = 1; next pc = 0x0040.
- halt_req in the same cycle as a taken branch → branch taken, no halt. halt_req alone → pc frozen, halted = 1 one cycle later; then rst → pc = 0x0000, halted = 0.
- pc = 0xFFFE, no stall → next pc = 0x0000. Assert rst while in PEND → pend_tgt discarded, pc = 0x0000, state = RUN.
